// File: rtl/instr_feeder_if.sv
// Bus between the program feeder and its host/processor side.
// The feeder itself binds to the slave modport; the host side uses master.
interface instr_feeder_if #(
  parameter int ADDR_W = 5
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic              start;
  logic [ADDR_W-1:0] last_addr;
  logic              done;
  logic              incr_pc;
  logic [15:0]       din;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              finished;

  modport master (
    output load_en, load_addr, load_data, start, last_addr, done, incr_pc,
    input  din, run, pc, busy, finished
  );

  modport slave (
    input  load_en, load_addr, load_data, start, last_addr, done, incr_pc,
    output din, run, pc, busy, finished
  );
endinterface

// File: rtl/instr_feeder.sv
// Program memory plus sequencer that feeds 16-bit words to a processor's din.
// States:
//   IDLE  | waiting for start after reset
//   FETCH | one-cycle load of mem[pc] onto din, run asserted on exit
//   RUN   | run held high until the processor reports done
//   END   | program finished, finished held until the next start
module instr_feeder #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5   // DEPTH must be 2**ADDR_W so pc wraps naturally
) (
  input  logic         clock,
  input  logic         resetn,
  instr_feeder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_END} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, last_q, last_d, pc_inc;
  logic [15:0]       din_q, din_d;
  logic              run_q, run_d, busy_q, busy_d, fin_q, fin_d;
  logic              loadable;
  logic [15:0]       mem [DEPTH];

  assign pc_inc   = pc_q + 1'b1;
  assign loadable = (state_q == S_IDLE) || (state_q == S_END);

  // Memory has no reset so a program survives resetn.
  always_ff @(posedge clock) begin
    if (bus.load_en && loadable) mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      din_q   <= din_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_END: if (bus.start) state_d = S_FETCH;
      S_FETCH:       state_d = S_RUN;
      S_RUN:         if (bus.done) state_d = (pc_q == last_q) ? S_END : S_FETCH;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    last_d = last_q;
    din_d  = din_q;
    run_d  = run_q;
    busy_d = busy_q;
    fin_d  = fin_q;
    case (state_q)
      S_IDLE, S_END: begin
        if (bus.start) begin
          last_d = bus.last_addr;
          pc_d   = '0;
          fin_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      S_FETCH: begin
        din_d = mem[pc_q];
        run_d = 1'b1;
      end
      S_RUN: begin
        // done wins over a simultaneous incr_pc so pc moves by one only
        if (bus.done) begin
          run_d = 1'b0;
          if (pc_q == last_q) begin
            busy_d = 1'b0;
            fin_d  = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end else if (bus.incr_pc) begin
          pc_d  = pc_inc;
          din_d = mem[pc_inc];
        end
      end
      default: ;
    endcase
  end

  assign bus.din      = din_q;
  assign bus.run      = run_q;
  assign bus.pc       = pc_q;
  assign bus.busy     = busy_q;
  assign bus.finished = fin_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Randomized scoreboard bench: the driver predicts each presented word or
// completion from a program-memory model, and a negedge monitor checks them.
module tb_instr_feeder;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  typedef struct {
    bit         fin;
    logic [4:0] pc;
    logic [15:0] din;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  instr_feeder_if #(.ADDR_W(AW)) bus ();
  instr_feeder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  exp_t        exp_q[$];
  logic [15:0] mem_m [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!bus.run && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("run_timeout", bus.run, 1);
  endtask

  // mode: 0 random, 1 plain done, 2 one incr_pc on first word,
  //       3 done+incr_pc together on first word, 4 stop in RUN at pc 3
  task automatic run_program(input logic [4:0] l, input int mode, output bit aborted);
    logic [4:0] p;
    int n_incr, w, r;
    bit fin, do_incr, do_done;
    aborted = 1'b0;
    fin = 1'b0;
    exp_q.push_back('{1'b0, 5'd0, mem_m[0]});
    bus.start = 1'b1;
    bus.last_addr = l;
    tick();
    bus.start = 1'b0;
    bus.last_addr = 5'($urandom);
    chk("fetch_run_low", bus.run, 0);
    chk("busy_set", bus.busy, 1);
    chk("finished_clr", bus.finished, 0);
    tick();
    chk("start_to_run", bus.run, 1);
    p = 5'd0;
    n_incr = 0;
    while (!fin) begin
      if (mode == 4 && p == 5'd3) begin
        aborted = 1'b1;
        return;
      end
      w = (mode == 0) ? int'($urandom_range(0, 3)) : 2;
      repeat (w) begin
        if (mode == 0 && $urandom_range(0, 3) == 0) begin
          bus.load_en   = 1'b1;
          bus.load_addr = 5'($urandom);
          bus.load_data = 16'($urandom);
        end
        if (mode == 0 && $urandom_range(0, 3) == 0) begin
          bus.start = 1'b1;
          bus.last_addr = 5'($urandom);
        end
        tick();
        bus.load_en = 1'b0;
        bus.start = 1'b0;
      end
      do_incr = 1'b0;
      do_done = 1'b1;
      case (mode)
        0: begin
          r = int'($urandom_range(0, 5));
          if (n_incr < 2 && r < 2) begin do_incr = 1'b1; do_done = 1'b0; end
          else if (r == 2) do_incr = 1'b1;
        end
        2: if (p == 5'd0 && n_incr == 0) begin do_incr = 1'b1; do_done = 1'b0; end
        3: if (p == 5'd0) do_incr = 1'b1;
        default: ;
      endcase
      if (!do_done) begin
        p = p + 5'd1;
        exp_q.push_back('{1'b0, p, mem_m[p]});
        n_incr++;
        bus.incr_pc = 1'b1;
        tick();
        bus.incr_pc = 1'b0;
        chk("run_held", bus.run, 1);
      end else begin
        if (p == l) begin
          exp_q.push_back('{1'b1, p, 16'h0});
          fin = 1'b1;
        end else begin
          p = p + 5'd1;
          exp_q.push_back('{1'b0, p, mem_m[p]});
        end
        bus.done = 1'b1;
        bus.incr_pc = do_incr;
        tick();
        bus.done = 1'b0;
        bus.incr_pc = 1'b0;
        chk("run_drop", bus.run, 0);
        if (!fin) begin
          n_incr = 0;
          wait_run();
        end
      end
    end
    chk("busy_clear", bus.busy, 0);
    chk("finished_set", bus.finished, 1);
    chk("pc_final", bus.pc, l);
  endtask

  // Monitor
  logic        run_p = 1'b0, fin_p = 1'b0, busy_p = 1'b0;
  logic [4:0]  pc_p = '0;
  logic [15:0] din_p = '0;
  int          gap = -1;
  exp_t        e;

  always @(negedge clock) begin
    if (resetn) begin
      if (bus.run && (!run_p || bus.pc != pc_p)) begin
        if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("word_kind", e.fin, 0);
          chk("word_pc", bus.pc, e.pc);
          chk("word_din", bus.din, e.din);
        end
      end
      if (bus.finished && !fin_p) begin
        if (exp_q.size() == 0) chk("unexpected_finish", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("fin_kind", e.fin, 1);
          chk("fin_pc", bus.pc, e.pc);
          chk("fin_run", bus.run, 0);
        end
      end
      if (run_p && !bus.run && bus.busy) gap = 1;
      else if (gap >= 0 && !bus.run) gap++;
      if (bus.run && !run_p && gap >= 0) begin
        chk("run_gap", gap, 1);
        gap = -1;
      end
      if (!bus.busy && !busy_p) chk("din_hold", bus.din, din_p);
    end else begin
      gap = -1;
    end
    run_p  = bus.run;
    fin_p  = bus.finished;
    busy_p = bus.busy;
    pc_p   = bus.pc;
    din_p  = bus.din;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    logic [4:0] l;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.last_addr = '0;
    bus.done      = 1'b0;
    bus.incr_pc   = 1'b0;
    #1;
    chk("rst_pc", bus.pc, 0);
    chk("rst_run", bus.run, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fin", bus.finished, 0);
    chk("rst_din", bus.din, 0);
    tick();
    tick();
    resetn = 1'b1;
    for (int a = 0; a < DEPTH; a++) load(5'(a), 16'($urandom));

    load(5'd0, 16'h0002);
    load(5'd1, 16'h0003);
    run_program(5'd1, 1, ab);

    load(5'd0, 16'h0040);
    load(5'd1, 16'h0005);
    load(5'd2, 16'h0100);
    run_program(5'd2, 2, ab);

    run_program(5'd3, 3, ab);

    load(5'd31, 16'($urandom));
    run_program(5'd0, 1, ab);
    bus.done = 1'b1;
    bus.incr_pc = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.incr_pc = 1'b0;
    tick();
    chk("ignored_pc", bus.pc, 0);
    chk("ignored_fin", bus.finished, 1);
    chk("ignored_run", bus.run, 0);

    for (int a = 0; a < 6; a++) load(5'(a), 16'($urandom));
    run_program(5'd5, 4, ab);
    chk("abort_reached", ab, 1);
    chk("abort_pc", bus.pc, 3);
    #1 resetn = 1'b0;
    #1;
    chk("async_pc", bus.pc, 0);
    chk("async_run", bus.run, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_din", bus.din, 0);
    chk("async_fin", bus.finished, 0);
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_run", bus.run, 0);
    chk("idle_pc", bus.pc, 0);
    run_program(5'd5, 1, ab);

    repeat (25) begin
      repeat ($urandom_range(0, 3)) load(5'($urandom), 16'($urandom));
      l = 5'($urandom);
      run_program(l, 0, ab);
    end

    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
